ntt_batch_mem_sequencer: RTL and testbench
==========================================

// Module: ntt_batch_mem_sequencer
// PURPOSE
//   Memory-side sequencer for the SDF NTT core, generalised to NUM_POLY back-to-back polynomials.
//   Streams coefficients from a coefficient BRAM into the core and writes core outputs back with a
//   per-job output ordering (natural / bit-reversed / negacyclic-reflected bit-reversed).
//   Sits between the polynomial BRAM and the NTT core; a top controller drives start/done.
// PARAMETERS
//   LOGQ        64  coefficient width in bits
//   LOGN        10  log2 of polynomial length N
//   NUM_POLY    4   polynomials per job (>=1); memory holds poly p at base p*N
//   PW          2   address bits for polynomial index, =max(1,clog2(NUM_POLY))
//   START_DLY   10  cycles from accepted start to first read (>=1)
//   RD_LAT      2   BRAM read latency in cycles (>=1)
// PORTS
//   clk            in   1          clock
//   rst_n          in   1          reset (see BEHAVIOUR)
//   start          in   1          job request, accepted only in IDLE
//   order          in   2          output ordering, sampled with accepted start
//   busy           out  1          high from accepted start until done
//   done           out  1          one-cycle pulse after last write
//   rd_en          out  1          BRAM read strobe
//   rd_addr        out  LOGN+PW    BRAM read address
//   rd_data        in   LOGQ       BRAM read data, valid RD_LAT cycles after rd_en
//   wr_en          out  1          BRAM write strobe
//   wr_addr        out  LOGN+PW    BRAM write address
//   wr_data        out  LOGQ       BRAM write data
//   core_start     out  1          one-cycle pulse per polynomial, with its first core_in_valid
//   core_in_valid  out  1          core input sample valid
//   core_in        out  LOGQ       core input sample (= rd_data)
//   core_out_valid in   1          core output sample valid
//   core_out       in   LOGQ       core output sample
// BEHAVIOUR
//   Clocking/reset: one clock; reset is asynchronous and active-low.
//   - rst_n low: FSM->IDLE, all counters 0; busy, done, rd_en, wr_en, core_start, core_in_valid = 0.
//   - Reset mid-job aborts immediately; no further reads/writes; job is not resumed.
//   FSM: IDLE -> WAIT -> STREAM -> DRAIN -> IDLE.
//   - IDLE: start=1 latches order, clears counters, busy=1 next cycle, -> WAIT. start elsewhere ignored.
//   - WAIT: count START_DLY cycles, -> STREAM.
//   - STREAM: rd_en=1 every cycle, rd_addr 0..NUM_POLY*N-1 contiguous; after last read -> DRAIN.
//   - DRAIN: wait until write count = NUM_POLY*N; then done=1 for one cycle, busy=0, -> IDLE.
//   Read path: core_in_valid = rd_en delayed RD_LAT cycles; core_in = rd_data (combinational).
//   - core_start asserted in the cycle the sample with rd_addr[LOGN-1:0]==0 reaches core_in_valid.
//   Write path (wcnt = coefficient index 0..N-1, wpoly = polynomial index):
//   - wr_en = core_out_valid while busy and total writes < NUM_POLY*N; wr_data = core_out.
//   - wr_addr = {wpoly, map(wcnt)}; wcnt increments per write, wraps N-1->0 and increments wpoly.
//   - map: order 0 -> wcnt; 1 -> br(wcnt); 2 -> (br(wcnt)==0) ? 0 : N-br(wcnt), mod N; 3 -> as 0.
//   - br = LOGN-bit bit reversal.
//   - core_out_valid outside busy or after final write: ignored, no wr_en.
//   - Reads and writes may overlap (different polynomials); no arbitration, dual-port BRAM.
//   - start coincident with done cycle: ignored (FSM not yet IDLE).
//   Widths: counters LOGN+PW+1 bits, no overflow for NUM_POLY*N; map arithmetic modulo 2^LOGN.
// TESTING (LOGN=3, N=8, NUM_POLY=2, START_DLY=10, RD_LAT=2)
//   1 start, order=0, core echoes core_in after 20 cycles -> first rd_en 10 cycles after start,
//     16 reads addr 0..15, 16 writes addr 0..15, done single pulse, busy low after.
//   2 order=1 -> wr_addr sequence poly0: 0,4,2,6,1,5,3,7; poly1: 8,12,10,14,9,13,11,15.
//   3 order=2 -> poly0 wr_addr: 0,4,6,2,7,3,5,1 (wcnt=3 -> br=6 -> 2).
//   4 start pulsed while busy and on done cycle -> no restart, exactly one done, order unchanged.
//   5 rst_n low at write 5 of poly0 -> all outputs 0 same cycle; new start runs clean full job.
//   6 core_out_valid gaps (valid every other cycle) and extra valids after job -> 16 writes only,
//     wr_addr advances only on valid, core_start pulses exactly twice.

Source files
------------

// File: rtl/ntt_batch_mem_sequencer.sv
// Memory-side sequencer for a batched SDF NTT core: streams NUM_POLY
// polynomials from BRAM into the core and writes results back reordered.
module ntt_batch_mem_sequencer #(
  parameter int LOGQ      = 64,
  parameter int LOGN      = 10,
  parameter int NUM_POLY  = 4,
  parameter int PW        = 2,
  parameter int START_DLY = 10,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           order,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [LOGN+PW-1:0]   rd_addr,
  input  logic [LOGQ-1:0]      rd_data,
  output logic                 wr_en,
  output logic [LOGN+PW-1:0]   wr_addr,
  output logic [LOGQ-1:0]      wr_data,
  output logic                 core_start,
  output logic                 core_in_valid,
  output logic [LOGQ-1:0]      core_in,
  input  logic                 core_out_valid,
  input  logic [LOGQ-1:0]      core_out
);

  localparam int AW    = LOGN + PW;
  localparam int CW    = LOGN + PW + 1;
  localparam int TOTAL = NUM_POLY << LOGN;
  localparam int DW    = $clog2(START_DLY + 1);

  localparam logic [CW-1:0] TOT_C  = CW'(TOTAL);
  localparam logic [AW-1:0] LAST_A = AW'(TOTAL - 1);
  localparam logic [DW-1:0] DLY_C  = DW'(START_DLY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    DRAIN
  } state_t;

  state_t            state_q;
  logic [1:0]        order_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [AW-1:0]     raddr_q;
  logic [DW-1:0]     dly_q;
  logic [CW-1:0]     wtot_q;
  logic [LOGN-1:0]   wcnt_q;
  logic [PW-1:0]     wpoly_q;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] first_q;

  logic              wr_fire;
  logic [LOGN-1:0]   br;
  logic [LOGN-1:0]   map_d;

  assign wr_fire = core_out_valid & busy_q & (wtot_q < TOT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      order_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      raddr_q <= '0;
      dly_q   <= '0;
      wtot_q  <= '0;
      wcnt_q  <= '0;
      wpoly_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT;
            order_q <= order;
            busy_q  <= 1'b1;
            dly_q   <= '0;
            raddr_q <= '0;
            wtot_q  <= '0;
            wcnt_q  <= '0;
            wpoly_q <= '0;
          end
        end
        WAIT: begin
          if (dly_q == DLY_C) begin
            state_q <= STREAM;
            rd_en_q <= 1'b1;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        STREAM: begin
          if (raddr_q == LAST_A) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        DRAIN: begin
          // stay here through the done cycle so a start there is ignored
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wtot_q == TOT_C) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (wr_fire) begin
        wtot_q <= wtot_q + 1'b1;
        wcnt_q <= wcnt_q + 1'b1;
        if (&wcnt_q) begin
          wpoly_q <= wpoly_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      first_q <= '0;
    end else begin
      vld_q[0]   <= rd_en_q;
      first_q[0] <= rd_en_q & (raddr_q[LOGN-1:0] == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  always_comb begin
    br = '0;
    for (int i = 0; i < LOGN; i++) begin
      br[i] = wcnt_q[LOGN-1-i];
    end
  end

  // negacyclic reflection: N - br wraps to 0 for br == 0 in LOGN bits
  always_comb begin
    map_d = wcnt_q;
    unique case (1'b1)
      (order_q == 2'd1): map_d = br;
      (order_q == 2'd2): map_d = LOGN'(0) - br;
      default:           map_d = wcnt_q;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = raddr_q;
  assign core_in_valid = vld_q[RD_LAT-1];
  assign core_start    = first_q[RD_LAT-1];
  assign core_in       = rd_data;
  assign wr_en         = wr_fire;
  assign wr_addr       = {wpoly_q, map_d};
  assign wr_data       = core_out;

endmodule

// File: tb/tb_ntt_batch_mem_sequencer.sv
// Directed bench: BRAM and echoing-core models around the sequencer,
// one task per scenario with hand-computed address tables.
module tb_ntt_batch_mem_sequencer;

  localparam int LOGQ = 16;
  localparam int LOGN = 3;
  localparam int NP   = 2;
  localparam int PW   = 1;
  localparam int SD   = 10;
  localparam int RL   = 2;
  localparam int AW   = 4;

  logic            clk = 0;
  logic            rst_n = 0;
  logic            start = 0;
  logic [1:0]      order = 0;
  logic            busy, done, rd_en, wr_en;
  logic            core_start, core_in_valid;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [LOGQ-1:0] rd_data, wr_data, core_in;
  logic            core_out_valid = 0;
  logic [LOGQ-1:0] core_out = 0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_cs = 0;
  bit gap_mode = 0;
  bit extra_mode = 0;

  logic [LOGQ-1:0] mem [16];
  logic [LOGQ-1:0] p1;
  logic [AW-1:0]   ra_q [$];
  logic [AW-1:0]   wa_q [$];
  logic [LOGQ-1:0] wd_q [$];
  int              rt_q [$];
  logic [LOGQ-1:0] cq [$];
  int              ct [$];
  bit              ph;

  ntt_batch_mem_sequencer #(
    .LOGQ(LOGQ), .LOGN(LOGN), .NUM_POLY(NP),
    .PW(PW), .START_DLY(SD), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .order(order), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .core_start(core_start),
    .core_in_valid(core_in_valid),
    .core_in(core_in),
    .core_out_valid(core_out_valid),
    .core_out(core_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // two-cycle BRAM read pipeline
  always @(posedge clk) begin
    p1      <= mem[rd_addr];
    rd_data <= p1;
  end

  // core echoes each input ~20 cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq.delete();
      ct.delete();
      core_out_valid <= 0;
      ph <= 0;
    end else begin
      ph <= ~ph;
      if (core_in_valid) begin
        cq.push_back(core_in);
        ct.push_back(cyc);
      end
      if (ct.size() > 0 && cyc - ct[0] >= 19 &&
          (!gap_mode || ph)) begin
        core_out_valid <= 1;
        core_out <= cq[0];
        void'(cq.pop_front());
        void'(ct.pop_front());
      end else if (extra_mode) begin
        core_out_valid <= 1;
        core_out <= 16'hDEAD;
      end else begin
        core_out_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        ra_q.push_back(rd_addr);
        rt_q.push_back(cyc);
      end
      if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (done) n_done <= n_done + 1;
      if (core_start) n_cs <= n_cs + 1;
    end
  end

  function automatic int emap(input int ord, input int j);
    int t1 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int t2 [8] = '{0, 4, 6, 2, 7, 3, 5, 1};
    if (ord == 1) return t1[j];
    if (ord == 2) return t2[j];
    return j;
  endfunction

  task automatic run_job(input int ord, input bit gap,
                         input bit extra, input bit poke,
                         input string nm);
    int b_rd, b_wr, b_dn, b_cs, s, p, j, ea;
    logic [LOGQ-1:0] ed;
    bit got;
    b_rd = ra_q.size();
    b_wr = wa_q.size();
    b_dn = n_done;
    b_cs = n_cs;
    got = 0;
    gap_mode = gap;
    @(negedge clk);
    order = 2'(ord);
    start = 1;
    @(negedge clk);
    start = 0;
    s = cyc;
    for (int t = 0; t < 600 && !got; t++) begin
      @(negedge clk);
      start = 0;
      if (poke && t == 15) begin
        start = 1;
        order = 2'd1;
      end
      if (done) begin
        got = 1;
        if (poke) start = 1;
      end
    end
    @(negedge clk);
    start = 0;
    if (extra) begin
      extra_mode = 1;
      repeat (10) @(negedge clk);
      extra_mode = 0;
    end
    repeat (30) @(negedge clk);
    gap_mode = 0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s done_timeout: no done in 600 cycles", nm);
    end
    n_cmp++;
    if (ra_q.size() - b_rd !== 16) begin
      n_err++;
      $display("FAIL %s nreads: got %0d exp 16",
               nm, ra_q.size() - b_rd);
    end
    if (rt_q.size() > b_rd) begin
      n_cmp++;
      if (rt_q[b_rd] - s !== SD) begin
        n_err++;
        $display("FAIL %s first_rd_lat: got %0d exp %0d",
                 nm, rt_q[b_rd] - s, SD);
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (b_rd + i < ra_q.size()) begin
        n_cmp++;
        if (ra_q[b_rd+i] !== AW'(i)) begin
          n_err++;
          $display("FAIL %s rd_addr[%0d]: got %0d exp %0d",
                   nm, i, ra_q[b_rd+i], i);
        end
      end
    end
    n_cmp++;
    if (wa_q.size() - b_wr !== 16) begin
      n_err++;
      $display("FAIL %s nwrites: got %0d exp 16",
               nm, wa_q.size() - b_wr);
    end
    for (int i = 0; i < 16; i++) begin
      if (b_wr + i < wa_q.size()) begin
        p = i / 8;
        j = i % 8;
        ea = p * 8 + emap(ord, j);
        ed = LOGQ'(16'h1000 + (p * 8 + j) * 16'h0111);
        n_cmp++;
        if (wa_q[b_wr+i] !== AW'(ea)) begin
          n_err++;
          $display("FAIL %s wr_addr[%0d]: got %0d exp %0d",
                   nm, i, wa_q[b_wr+i], ea);
        end
        n_cmp++;
        if (wd_q[b_wr+i] !== ed) begin
          n_err++;
          $display("FAIL %s wr_data[%0d]: got %h exp %h",
                   nm, i, wd_q[b_wr+i], ed);
        end
      end
    end
    n_cmp++;
    if (n_done - b_dn !== 1) begin
      n_err++;
      $display("FAIL %s ndone: got %0d exp 1", nm, n_done - b_dn);
    end
    n_cmp++;
    if (n_cs - b_cs !== 2) begin
      n_err++;
      $display("FAIL %s core_start: got %0d exp 2", nm, n_cs - b_cs);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: busy=%b done=%b exp 0 0",
               nm, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, rd_en, wr_en, core_start, core_in_valid}
        !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b exp 000000",
               {busy, done, rd_en, wr_en, core_start, core_in_valid});
    end
    n_cmp++;
    if (rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr);
    end
    rst_n = 1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ra_q.size() !== 0) begin
      n_err++;
      $display("FAIL idle_no_start: busy=%b reads=%0d exp 0 0",
               busy, ra_q.size());
    end
  endtask

  task automatic test_natural();
    run_job(0, 0, 0, 0, "natural");
  endtask

  task automatic test_bitrev();
    run_job(1, 0, 0, 0, "bitrev");
  endtask

  task automatic test_negacyclic();
    run_job(2, 0, 0, 0, "negacyclic");
  endtask

  task automatic test_order3();
    run_job(3, 0, 0, 0, "order3");
  endtask

  task automatic test_start_ignored();
    run_job(0, 0, 0, 1, "start_ignored");
  endtask

  task automatic test_reset_mid_job();
    int b_rd, b_wr;
    b_wr = wa_q.size();
    @(negedge clk);
    order = 2'd0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 400 && wa_q.size() - b_wr < 5; t++)
      @(negedge clk);
    n_cmp++;
    if (wa_q.size() - b_wr < 5) begin
      n_err++;
      $display("FAIL midrst_wait: writes %0d exp >=5",
               wa_q.size() - b_wr);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, rd_en, wr_en, core_start, core_in_valid}
        !== 6'b0) begin
      n_err++;
      $display("FAIL midrst_outs: got %b exp 000000",
               {busy, done, rd_en, wr_en, core_start, core_in_valid});
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    b_rd = ra_q.size();
    b_wr = wa_q.size();
    repeat (40) @(negedge clk);
    n_cmp++;
    if (ra_q.size() != b_rd || wa_q.size() != b_wr ||
        busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_resumed: rd=%0d wr=%0d busy=%b exp 0 0 0",
               ra_q.size() - b_rd, wa_q.size() - b_wr, busy);
    end
    run_job(2, 0, 0, 0, "post_reset");
  endtask

  task automatic test_back_to_back_gaps();
    run_job(1, 1, 1, 0, "gaps_extra");
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      mem[i] = LOGQ'(16'h1000 + i * 16'h0111);
    test_reset();
    test_natural();
    test_bitrev();
    test_negacyclic();
    test_order3();
    test_start_ignored();
    test_reset_mid_job();
    test_back_to_back_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
